// File: rtl/tlm_pkg.sv
// Shared codes, phase encoding, error payload and legal-transition table
// for the intersection light monitor.
package tlm_pkg;

  localparam int unsigned CODE_W  = 2;
  localparam int unsigned PHASE_W = 3;
  localparam int unsigned LEN_W   = 6;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned CYC_W   = 16;

  localparam logic [CODE_W-1:0] CAR_RED     = 2'b00;
  localparam logic [CODE_W-1:0] CAR_GREEN   = 2'b01;
  localparam logic [CODE_W-1:0] CAR_YELLOW  = 2'b10;
  localparam logic [CODE_W-1:0] CAR_LEFT    = 2'b11;

  localparam logic [CODE_W-1:0] HMN_RED     = 2'b00;
  localparam logic [CODE_W-1:0] HMN_GREEN   = 2'b01;
  localparam logic [CODE_W-1:0] HMN_BLINK   = 2'b10;
  localparam logic [CODE_W-1:0] HMN_ILLEGAL = 2'b11;

  typedef enum logic [PHASE_W-1:0] {
    ALL_RED = 3'd0,
    CAR_GO  = 3'd1,
    CAR_YEL = 3'd2,
    LEFT    = 3'd3,
    HMN_GO  = 3'd4,
    HMN_BLK = 3'd5,
    BAD     = 3'd7
  } phase_e;

  typedef struct packed {
    logic conflict;
    logic code;
    logic seq;
    logic len;
    logic stuck;
  } tlm_err_t;

  // Legal successor table of the controller's signal sequence.
  function automatic logic tlm_legal(input phase_e from_ph, input phase_e to_ph);
    logic ok;
    ok = 1'b0;
    case (from_ph)
      ALL_RED: ok = (to_ph == CAR_GO) || (to_ph == HMN_GO);
      CAR_GO:  ok = (to_ph == CAR_YEL);
      CAR_YEL: ok = (to_ph == LEFT) || (to_ph == HMN_GO) || (to_ph == ALL_RED);
      LEFT:    ok = (to_ph == CAR_YEL);
      HMN_GO:  ok = (to_ph == HMN_BLK);
      HMN_BLK: ok = (to_ph == ALL_RED);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/traffic_light_monitor_if.sv
// Observation bus between the light controller side (master) and the
// passive monitor (slave), plus the monitor's status outputs.
interface traffic_light_monitor_if;
  import tlm_pkg::*;

  logic                 clr;
  logic [CODE_W-1:0]    car_light;
  logic [CODE_W-1:0]    hmn_light;
  logic [PHASE_W-1:0]   phase;
  logic [LEN_W-1:0]     phase_len;
  logic                 locked;
  logic                 err_conflict;
  logic                 err_code;
  logic                 err_seq;
  logic                 err_len;
  logic                 err_stuck;
  logic [CNT_W-1:0]     err_count;
  logic [CYC_W-1:0]     cycle_cnt;

  modport master (
    output clr, car_light, hmn_light,
    input  phase, phase_len, locked,
    input  err_conflict, err_code, err_seq, err_len, err_stuck,
    input  err_count, cycle_cnt
  );

  modport slave (
    input  clr, car_light, hmn_light,
    output phase, phase_len, locked,
    output err_conflict, err_code, err_seq, err_len, err_stuck,
    output err_count, cycle_cnt
  );

endinterface

// File: rtl/tlm_phase_decode.sv
// Combinational decode of a (car, pedestrian) light pair into a phase,
// with the unsafe-combination and illegal-code flags.
module tlm_phase_decode
  import tlm_pkg::*;
(
  input  logic [CODE_W-1:0] car_i,
  input  logic [CODE_W-1:0] hmn_i,
  output phase_e            phase_c,
  output logic              conflict_c,
  output logic              code_c
);

  always_comb begin
    phase_c = BAD;
    case ({car_i, hmn_i})
      {CAR_RED,    HMN_RED}:   phase_c = ALL_RED;
      {CAR_GREEN,  HMN_RED}:   phase_c = CAR_GO;
      {CAR_YELLOW, HMN_RED}:   phase_c = CAR_YEL;
      {CAR_LEFT,   HMN_RED}:   phase_c = LEFT;
      {CAR_RED,    HMN_GREEN}: phase_c = HMN_GO;
      {CAR_RED,    HMN_BLINK}: phase_c = HMN_BLK;
      default:                 phase_c = BAD;
    endcase
  end

  assign conflict_c = (car_i != CAR_RED) && ((hmn_i == HMN_GREEN) || (hmn_i == HMN_BLINK));
  assign code_c     = (hmn_i == HMN_ILLEGAL);

endmodule

// File: rtl/traffic_light_monitor.sv
// Passive checker for the intersection light controller: tracks phases,
// durations and transitions and reports error pulses and counters.
// Optional signal-cycle counter enabled by defining TLM_CYCLE_CNT_EN.
module traffic_light_monitor
  import tlm_pkg::*;
#(
  parameter int unsigned YEL_CYC   = 2,
  parameter int unsigned BLK_CYC   = 6,
  parameter int unsigned MAX_PHASE = 40
) (
  input  logic                   clk,
  input  logic                   rst_n,
  traffic_light_monitor_if.slave mon
);

  localparam logic [LEN_W-1:0] LEN_SAT = '1;
  localparam logic [CNT_W-1:0] CNT_SAT = '1;

  logic [CODE_W-1:0] car_q, hmn_q;
  phase_e            cur_ph;
  logic              conflict, code;

  phase_e            phase_q;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              locked_q, locked_d;
  tlm_err_t          err_q, err_d;
  logic              chg;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;

  // Input sampling stage; reset value decodes as ALL_RED.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      car_q <= CAR_RED;
      hmn_q <= HMN_RED;
    end else begin
      car_q <= mon.car_light;
      hmn_q <= mon.hmn_light;
    end
  end

  tlm_phase_decode u_decode (
    .car_i      (car_q),
    .hmn_i      (hmn_q),
    .phase_c    (cur_ph),
    .conflict_c (conflict),
    .code_c     (code)
  );

  assign chg = (cur_ph != phase_q);

  // Phase tracker: compares the new sample against the previous phase.
  always_comb begin
    locked_d       = locked_q;
    err_d          = '0;
    len_d          = (len_q == LEN_SAT) ? len_q : len_q + LEN_W'(1);
    err_d.conflict = conflict;
    err_d.code     = code;
    if (chg) begin
      len_d = LEN_W'(1);
      if (cur_ph == BAD) begin
        locked_d = 1'b0;
      end else if (phase_q != BAD) begin
        if (locked_q && !tlm_legal(phase_q, cur_ph)) err_d.seq = 1'b1;
        else                                         locked_d  = 1'b1;
      end
      if (locked_q && (phase_q == CAR_YEL) && (len_q != LEN_W'(YEL_CYC))) err_d.len = 1'b1;
      if (locked_q && (phase_q == HMN_BLK) && (len_q != LEN_W'(BLK_CYC))) err_d.len = 1'b1;
    end
    err_d.stuck = !chg && (len_q == LEN_W'(MAX_PHASE - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q  <= ALL_RED;
      len_q    <= '0;
      locked_q <= 1'b0;
      err_q    <= '0;
    end else begin
      phase_q  <= cur_ph;
      len_q    <= len_d;
      locked_q <= locked_d;
      err_q    <= err_d;
    end
  end

  // One count per cycle with any pulse; clear has priority.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (mon.clr)                            err_cnt_d = '0;
    else if ((|err_q) && (err_cnt_q != CNT_SAT)) err_cnt_d = err_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_cnt_q <= '0;
    else        err_cnt_q <= err_cnt_d;
  end

`ifdef TLM_CYCLE_CNT_EN
  logic             entry_q, entry_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;

  // A signal cycle completes on each locked ALL_RED -> CAR_GO entry.
  always_comb begin
    entry_d = 1'b0;
    if (chg && locked_q && (phase_q == ALL_RED) && (cur_ph == CAR_GO)) entry_d = 1'b1;
  end

  always_comb begin
    cyc_d = cyc_q;
    if (mon.clr)      cyc_d = '0;
    else if (entry_q) cyc_d = cyc_q + CYC_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry_q <= 1'b0;
      cyc_q   <= '0;
    end else begin
      entry_q <= entry_d;
      cyc_q   <= cyc_d;
    end
  end

  assign mon.cycle_cnt = cyc_q;
`else
  assign mon.cycle_cnt = '0;
`endif

  assign mon.phase        = phase_q;
  assign mon.phase_len    = len_q;
  assign mon.locked       = locked_q;
  assign mon.err_conflict = err_q.conflict;
  assign mon.err_code     = err_q.code;
  assign mon.err_seq      = err_q.seq;
  assign mon.err_len      = err_q.len;
  assign mon.err_stuck    = err_q.stuck;
  assign mon.err_count    = err_cnt_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Scoreboard bench for traffic_light_monitor: a behavioural model predicts
// each sample's outputs, which are compared when they reach the ports.
module tb_traffic_light_monitor;

  localparam int unsigned YEL  = 2;
  localparam int unsigned BLK  = 6;
  localparam int unsigned MAXP = 40;
`ifdef TLM_CYCLE_CNT_EN
  localparam bit CYC_EN = 1'b1;
`else
  localparam bit CYC_EN = 1'b0;
`endif

  localparam logic [2:0] P_AR = 3'd0, P_CG = 3'd1, P_CY = 3'd2, P_LT = 3'd3;
  localparam logic [2:0] P_HG = 3'd4, P_HB = 3'd5, P_BAD = 3'd7;

  typedef struct packed {
    logic [2:0] ph;
    logic [5:0] len;
    logic       lock;
    logic [4:0] err;   // conflict, code, seq, len, stuck
    logic       entry;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  traffic_light_monitor_if mon_if ();
  traffic_light_monitor dut (.clk(clk), .rst_n(rst_n), .mon(mon_if));

  exp_t        sbq[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [2:0]  m_ph;
  logic [5:0]  m_len;
  logic        m_lock;
  logic [7:0]  m_cnt;
  logic [15:0] m_cyc;
  logic        last_any, last_entry;
  int          seen_conf, seen_code, seen_seq, seen_len, seen_stuck;

  function automatic logic [2:0] m_decode(input logic [1:0] c, input logic [1:0] h);
    if (h == 2'd0) return c;   // car code doubles as phase number when pedestrians are red
    if (c == 2'd0 && h == 2'd1) return P_HG;
    if (c == 2'd0 && h == 2'd2) return P_HB;
    return P_BAD;
  endfunction

  function automatic bit m_legal(input logic [2:0] a, input logic [2:0] b);
    return (a == P_AR && (b == P_CG || b == P_HG)) || (a == P_CG && b == P_CY) ||
           (a == P_CY && (b == P_LT || b == P_HG || b == P_AR)) || (a == P_LT && b == P_CY) ||
           (a == P_HG && b == P_HB) || (a == P_HB && b == P_AR);
  endfunction

  task automatic model_push(input logic [1:0] c, input logic [1:0] h);
    exp_t e;
    logic [2:0] cur;
    logic chg, lock, sq, ln, stk;
    logic [5:0] nlen;
    cur  = m_decode(c, h);
    chg  = (cur != m_ph);
    lock = m_lock; sq = 1'b0; ln = 1'b0;
    e    = '0;
    if (chg) begin
      if (cur == P_BAD) lock = 1'b0;
      else if (m_ph != P_BAD) begin
        if (m_lock && !m_legal(m_ph, cur)) sq = 1'b1;
        else lock = 1'b1;
      end
      if (m_lock && m_ph == P_CY && m_len != 6'(YEL)) ln = 1'b1;
      if (m_lock && m_ph == P_HB && m_len != 6'(BLK)) ln = 1'b1;
      e.entry = m_lock && m_ph == P_AR && cur == P_CG;
    end
    nlen = chg ? 6'd1 : ((m_len == 6'd63) ? 6'd63 : m_len + 6'd1);
    stk  = !chg && nlen == 6'(MAXP);
    e.ph = cur; e.len = nlen; e.lock = lock;
    e.err = {(c != 2'd0) && (h == 2'd1 || h == 2'd2), h == 2'd3, sq, ln, stk};
    sbq.push_back(e);
    m_ph = cur; m_len = nlen; m_lock = lock;
  endtask

  task automatic model_reset();
    sbq.delete();
    m_ph = P_AR; m_len = 6'd0; m_lock = 1'b0;
    m_cnt = 8'd0; m_cyc = 16'd0; last_any = 1'b0; last_entry = 1'b0;
    seen_conf = 0; seen_code = 0; seen_seq = 0; seen_len = 0; seen_stuck = 0;
    model_push(2'd0, 2'd0);
  endtask

  // Drive one sample at the falling edge; compare the sample in flight one clock earlier.
  task automatic step(input logic [1:0] c, input logic [1:0] h, input logic clr);
    exp_t e;
    logic [38:0] act, req;
    mon_if.car_light = c;
    mon_if.hmn_light = h;
    mon_if.clr       = clr;
    model_push(c, h);
    @(posedge clk);
    @(negedge clk);
    if (sbq.size() >= 2) begin
      e = sbq.pop_front();
      if (clr) m_cnt = 8'd0;
      else if (last_any && m_cnt != 8'd255) m_cnt = m_cnt + 8'd1;
      if (CYC_EN) m_cyc = clr ? 16'd0 : m_cyc + 16'(last_entry);
      last_any = |e.err; last_entry = e.entry;
      act = {mon_if.phase, mon_if.phase_len, mon_if.locked, mon_if.err_conflict, mon_if.err_code,
             mon_if.err_seq, mon_if.err_len, mon_if.err_stuck, mon_if.err_count, mon_if.cycle_cnt};
      req = {e.ph, e.len, e.lock, e.err, m_cnt, m_cyc};
      vectors++;
      if (act !== req) begin
        miscompares++;
        $display("FAIL sb t=%0t: got ph=%0d len=%0d lk=%b err=%b cnt=%0d cyc=%0d, want ph=%0d len=%0d lk=%b err=%b cnt=%0d cyc=%0d",
                 $time, act[38:36], act[35:30], act[29], act[28:24], act[23:16], act[15:0],
                 req[38:36], req[35:30], req[29], req[28:24], req[23:16], req[15:0]);
      end
      seen_conf  += int'(mon_if.err_conflict);
      seen_code  += int'(mon_if.err_code);
      seen_seq   += int'(mon_if.err_seq);
      seen_len   += int'(mon_if.err_len);
      seen_stuck += int'(mon_if.err_stuck);
    end
  endtask

  task automatic run(input logic [1:0] c, input logic [1:0] h, input int n);
    for (int i = 0; i < n; i++) step(c, h, 1'b0);
  endtask

  task automatic run_cycle();
    run(2'd1, 2'd0, 25); run(2'd2, 2'd0, 2); run(2'd3, 2'd0, 12); run(2'd2, 2'd0, 2);
    run(2'd0, 2'd1, 16); run(2'd0, 2'd2, 6); run(2'd0, 2'd0, 6);
  endtask

  task automatic apply_reset();
    mon_if.car_light = 2'd0; mon_if.hmn_light = 2'd0; mon_if.clr = 1'b0;
    rst_n = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic chk(input string name, input int got, input int want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic test_reset();
    mon_if.car_light = 2'd0; mon_if.hmn_light = 2'd0; mon_if.clr = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    vectors++;
    if ({mon_if.phase, mon_if.phase_len, mon_if.locked, mon_if.err_count, mon_if.cycle_cnt} !== 34'd0) begin
      miscompares++;
      $display("FAIL reset_state: got ph=%0d len=%0d lk=%b cnt=%0d cyc=%0d want all 0",
               mon_if.phase, mon_if.phase_len, mon_if.locked, mon_if.err_count, mon_if.cycle_cnt);
    end
    vectors++;
    if ({mon_if.err_conflict, mon_if.err_code, mon_if.err_seq, mon_if.err_len, mon_if.err_stuck} !== 5'd0) begin
      miscompares++;
      $display("FAIL reset_pulses: got %b want 00000",
               {mon_if.err_conflict, mon_if.err_code, mon_if.err_seq, mon_if.err_len, mon_if.err_stuck});
    end
    rst_n = 1'b1;
    model_reset();
    run(2'd0, 2'd0, 3);
  endtask

  task automatic test_normal();
    apply_reset();
    run(2'd0, 2'd0, 3);
    repeat (3) run_cycle();
    run(2'd1, 2'd0, 4);
    chk("normal_errs", seen_conf + seen_code + seen_seq + seen_len + seen_stuck, 0);
    chk("normal_locked", int'(mon_if.locked), 1);
    chk("normal_cycle_cnt", int'(mon_if.cycle_cnt), CYC_EN ? 3 : 0);
    chk("normal_err_count", int'(mon_if.err_count), 0);
  endtask

  task automatic test_conflict();
    apply_reset();
    run(2'd0, 2'd0, 2); run(2'd1, 2'd0, 5);
    step(2'd1, 2'd1, 1'b0);
    run(2'd1, 2'd0, 5);
    chk("conflict_pulses", seen_conf, 1);
    chk("conflict_err_count", int'(mon_if.err_count), 1);
    chk("conflict_seq", seen_seq, 0);
  endtask

  task automatic test_code();
    apply_reset();
    run(2'd0, 2'd0, 2); run(2'd1, 2'd0, 5);
    step(2'd0, 2'd3, 1'b0);
    step(2'd1, 2'd0, 1'b0);
    chk("code_pulse", int'(mon_if.err_code), 1);
    chk("code_unlocked", int'(mon_if.locked), 0);
    run(2'd1, 2'd0, 2); run(2'd2, 2'd0, 2); run(2'd3, 2'd0, 3); run(2'd2, 2'd0, 2);
    run(2'd0, 2'd1, 3); run(2'd0, 2'd2, 6); run(2'd0, 2'd0, 3);
    chk("code_relocked", int'(mon_if.locked), 1);
    chk("code_no_seq", seen_seq + seen_len, 0);
    chk("code_err_count", int'(mon_if.err_count), 1);
  endtask

  task automatic test_seq();
    apply_reset();
    run(2'd0, 2'd0, 2); run(2'd1, 2'd0, 5);
    step(2'd3, 2'd0, 1'b0);
    step(2'd3, 2'd0, 1'b0);
    chk("seq_pulse", int'(mon_if.err_seq), 1);
    step(2'd3, 2'd0, 1'b0);
    chk("seq_err_count", int'(mon_if.err_count), 1);
    run(2'd3, 2'd0, 2);
    chk("seq_single", seen_seq, 1);
  endtask

  task automatic test_len();
    apply_reset();
    run(2'd0, 2'd0, 2); run(2'd1, 2'd0, 4); run(2'd2, 2'd0, 3); run(2'd3, 2'd0, 3);
    run(2'd2, 2'd0, 2); run(2'd0, 2'd1, 4); run(2'd0, 2'd2, 6); run(2'd0, 2'd0, 3);
    chk("len_pulses", seen_len, 1);
    chk("len_no_seq", seen_seq, 0);
    chk("len_err_count", int'(mon_if.err_count), 1);
  endtask

  task automatic test_first_after_reset();
    apply_reset();
    run(2'd3, 2'd0, 3); run(2'd2, 2'd0, 2); run(2'd0, 2'd0, 3);
    chk("relock_no_seq", seen_seq + seen_len, 0);
    chk("relock_locked", int'(mon_if.locked), 1);
  endtask

  task automatic test_clr();
    apply_reset();
    run(2'd0, 2'd0, 2); run(2'd1, 2'd0, 3);
    step(2'd3, 2'd0, 1'b0);
    step(2'd3, 2'd0, 1'b0);
    step(2'd3, 2'd0, 1'b1);
    chk("clr_wins", int'(mon_if.err_count), 0);
    run(2'd3, 2'd0, 2);
    step(2'd1, 2'd0, 1'b0);
    step(2'd1, 2'd0, 1'b0);
    step(2'd1, 2'd0, 1'b0);
    chk("clr_recount", int'(mon_if.err_count), 1);
    step(2'd1, 2'd0, 1'b1);
    chk("clr_clears", int'(mon_if.err_count), 0);
  endtask

  task automatic test_stuck();
    apply_reset();
    run(2'd0, 2'd0, 2); run(2'd1, 2'd0, 40);
    step(2'd1, 2'd0, 1'b0);
    chk("stuck_at_max", int'(mon_if.err_stuck), 1);
    chk("stuck_len", int'(mon_if.phase_len), int'(MAXP));
    run(2'd1, 2'd0, 4);
    step(2'd1, 2'd0, 1'b0);
    chk("stuck_single", seen_stuck, 1);
    chk("stuck_len45", int'(mon_if.phase_len), 45);
    chk("stuck_err_count", int'(mon_if.err_count), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_outs", int'({mon_if.phase, mon_if.phase_len, mon_if.locked, mon_if.err_count}), 0);
    chk("midreset_pulses", int'({mon_if.err_conflict, mon_if.err_code, mon_if.err_seq,
                                 mon_if.err_len, mon_if.err_stuck}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    run(2'd0, 2'd0, 2); run(2'd1, 2'd0, 2);
  endtask

  initial begin
    rst_n = 1'b0;
    mon_if.car_light = 2'd0; mon_if.hmn_light = 2'd0; mon_if.clr = 1'b0;
    test_reset();
    test_normal();
    test_conflict();
    test_code();
    test_seq();
    test_len();
    test_first_after_reset();
    test_clr();
    test_stuck();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/traffic_light_monitor.md
# traffic_light_monitor

Passive checker that sits beside the intersection light controller and observes its `car_light`/`hmn_light` code outputs every clock. It decodes each light pair into a phase, and tracks phase transitions and durations against the legal signal sequence. It flags unsafe combinations, illegal codes, skipped phases, wrong yellow/blink lengths and stuck phases. It drives error pulses and a saturating error counter to the status/debug logic, and never feeds back into the controller.

## Interface
- `YEL_CYC`, default 2: required exact length of a car-yellow phase, in cycles.
- `BLK_CYC`, default 6: required exact length of a pedestrian-blink phase, in cycles.
- `MAX_PHASE`, default 40: phase length at which `err_stuck` fires; legal range 2..63.
- `clk`  in  1  system clock; single clock domain.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `clr`  in  1  synchronous clear of `err_count` and `cycle_cnt`.
- `car_light`  in  2  car code: 00 red, 01 green, 10 yellow, 11 left-turn.
- `hmn_light`  in  2  pedestrian code: 00 red, 01 green, 10 blink, 11 illegal.
- `phase`  out  3  decoded phase of the last sampled pair.
- `phase_len`  out  6  cycles spent in the current phase; saturates at 63.
- `locked`  out  1  monitor has seen at least one legal transition since reset or since the last BAD phase.
- `err_conflict`, `err_code`, `err_seq`, `err_len`, `err_stuck`  out  1 each  one-cycle error pulses.
- `err_count`  out  8  count of cycles with any error pulse; saturates at 255.
- `cycle_cnt`  out  16  count of completed signal cycles; wraps.

## Operation
- Phase decode of each (car, hmn) pair:
  - ALL_RED = (00,00)
  - CAR_GO = (01,00)
  - CAR_YEL = (10,00)
  - LEFT = (11,00)
  - HMN_GO = (00,01)
  - HMN_BLK = (00,10)
  - BAD = anything else.
- Legal transitions:
  - ALL_RED → CAR_GO or HMN_GO
  - CAR_GO → CAR_YEL
  - CAR_YEL → LEFT, HMN_GO or ALL_RED
  - LEFT → CAR_YEL
  - HMN_GO → HMN_BLK
  - HMN_BLK → ALL_RED
- Pulse conditions on a newly sampled pair:
  - `err_conflict`: car non-red while pedestrian is green or blink.
  - `err_code`: hmn = 11. If both this and `err_conflict` apply, both pulse.
- Phase change from P to Q, with neither phase BAD:
  - Illegal transition while `locked` → `err_seq`.
  - Otherwise `locked` sets.
- On exit from CAR_YEL or HMN_BLK while `locked`: if `phase_len` ≠ `YEL_CYC` or `BLK_CYC` respectively → `err_len`. The first phase after lock-loss is not length-checked.
- Entering BAD clears `locked` and raises no `err_seq`. Leaving BAD raises no `err_seq`.
- `phase_len` is 1 on the first cycle of a phase. `err_stuck` pulses once, on the cycle `phase_len` reaches `MAX_PHASE`. This includes BAD.
- `err_count` increments by exactly 1 per cycle with any pulse, regardless of how many pulses are active. `clr` wins over a same-cycle increment.

## Timing
- Pipeline: inputs registered at edge N. Decode and compare happen against the previous phase. Pulses, `phase` and `phase_len` are registered at edge N+1. Total latency is 2 edges from input change to pulse.
- `err_count`/`cycle_cnt` update at edge N+2. They reflect a pulse one cycle after it is visible.
- Reset values, all asynchronous:
  - Input regs: 0, so the initial sample is ALL_RED.
  - `phase` = ALL_RED, `phase_len` = 0.
  - `locked`, all error pulses, `err_count` and `cycle_cnt` = 0.
- Reset mid-sequence: all history is dropped and the monitor must relock. No error fires on the first transition after reset.

## Configuration
- `TLM_CYCLE_CNT_EN`:
  - Defined: `cycle_cnt` increments on every legal entry into CAR_GO while `locked`.
  - Undefined: the counter logic is removed and `cycle_cnt` is tied to 0. The port remains.

## Structure
- `tlm_pkg` holds:
  - the car and pedestrian light code localparams (00/01/10/11 as above);
  - the phase enum: ALL_RED=0, CAR_GO=1, CAR_YEL=2, LEFT=3, HMN_GO=4, HMN_BLK=5, BAD=7;
  - the legal-transition function.
- One sub-module, `tlm_phase_decode`: combinational (car, hmn) → phase plus conflict/code flags.

## Test plan
- Drive the controller's 69-cycle sequence (cars-first ordering) for 3 full cycles → all error pulses stay 0, `locked` = 1 after the first change, `cycle_cnt` = 3 (macro defined).
- Insert (01,01) for one cycle inside CAR_GO → one `err_conflict` pulse, then `err_count` = 1.
- Insert (00,11) for one cycle → `err_code`; `locked` drops; sequence resumes and relocks with no `err_seq`.
- CAR_GO directly to LEFT while locked → `err_seq` at edge N+1, `err_count` = 1.
- CAR_YEL held 3 cycles, then LEFT → `err_len` on exit. HMN_BLK held 6 cycles → no error.
- Hold CAR_GO for 45 cycles → single `err_stuck` on the 40th cycle. Assert `rst_n` low mid-phase → all outputs 0 immediately.
